groove_sample_scheduler: RTL and testbench

- Inverse of the groove sample timestamp path: converts a normalized signed 16-bit scan position into an absolute 32-bit timestamp within the current scan.
- Fires a one-cycle strobe when `sig_time` reaches that timestamp.
- Sits beside the timestamp block on the 100 MHz processing clock.
- Schedules per-channel actions (sample triggers, gate edges) at requested positions across the groove scan.

---
 rtl/groove_sample_scheduler.sv | 118 +++++++++++
 tb/tb_groove_sample_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/groove_sample_scheduler.sv
// groove_sample_scheduler: turns signed scan positions into absolute timestamps and strobes fire when sig_time reaches them.
// Define GROOVE_SCHED_SKIP_LATE_EN to drop late targets (missed only, no fire).
module groove_sample_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sync_start,
    input  logic [31:0] sig_time,
    input  logic        dir,
    input  logic [31:0] afll_ltr,
    input  logic [31:0] afll_rtl,
    input  logic        pos_valid,
    output logic        pos_ready,
    input  logic [15:0] pos_in,
    output logic        fire,
    output logic [31:0] fire_time,
    output logic        missed,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, READY, MUL1, MUL2, WAIT, FIRE} state_t;

    state_t             state;
    logic [15:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [31:0]        base, dur, dur_m, target, offset;
    logic [15:0]        pos;
    logic [16:0]        u;
    logic               first;
    logic               push, pop;
    logic signed [31:0] d;

    assign pos_ready = (state != IDLE) && (count != FULL) && !sync_start;
    assign push      = pos_valid && pos_ready;
    assign pop       = (state == READY) && (count != 0) && !sync_start;
    assign busy      = (count != 0) || (state inside {MUL1, MUL2, WAIT, FIRE});
    assign offset    = 32'((49'(u) * 49'(dur_m)) >> 16);
    // Modular difference keeps compares correct across the 32-bit wrap.
    assign d         = sig_time - target;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= pos_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            base      <= '0;
            dur       <= '0;
            dur_m     <= '0;
            target    <= '0;
            pos       <= '0;
            u         <= '0;
            first     <= 1'b0;
            fire      <= 1'b0;
            fire_time <= '0;
            missed    <= 1'b0;
        end else begin
            fire   <= 1'b0;
            missed <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (sync_start) begin
                state  <= READY;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                base   <= sig_time;
                dur    <= dir ? afll_rtl : afll_ltr;
            end else begin
                case (state)
                    READY: if (pop) begin
                        pos   <= mem[rd_ptr];
                        state <= MUL1;
                    end
                    MUL1: begin
                        u     <= {1'b0, ~pos[15], pos[14:0]};
                        dur_m <= dur;
                        state <= MUL2;
                    end
                    MUL2: begin
                        target <= base + offset;
                        first  <= 1'b1;
                        state  <= WAIT;
                    end
                    WAIT: begin
                        first <= 1'b0;
                        if (!d[31]) begin
                            missed <= first && (d != 0);
`ifdef GROOVE_SCHED_SKIP_LATE_EN
                            if (first && (d != 0)) begin
                                state <= READY;
                            end else begin
                                fire      <= 1'b1;
                                fire_time <= target;
                                state     <= FIRE;
                            end
`else
                            fire      <= 1'b1;
                            fire_time <= target;
                            state     <= FIRE;
`endif
                        end
                    end
                    FIRE:    state <= READY;
                    default: state <= state;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_groove_sample_scheduler.sv
// tb_groove_sample_scheduler: randomized and directed checks against a queue-based scheduling model.
module tb_groove_sample_scheduler;
    localparam int DEPTH = 4;

    logic        clk, reset, sync_start, dir, pos_valid, pos_ready;
    logic [31:0] sig_time, afll_ltr, afll_rtl, fire_time;
    logic [15:0] pos_in;
    logic        fire, missed, busy;

    groove_sample_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sync_start(sync_start), .sig_time(sig_time),
        .dir(dir), .afll_ltr(afll_ltr), .afll_rtl(afll_rtl),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_in(pos_in),
        .fire(fire), .fire_time(fire_time), .missed(missed), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: scheduled targets, pop/compare timing and late rule.
    bit          started;
    logic [31:0] m_base, m_dur, inf_t, m_ft;
    logic        inflight, m_fire, m_missed, m_busy;
    int          cyc, free_e, inf_c;
    logic [31:0] q[$];
    logic [31:0] obs_ft[$], obs_sig[$];
    int          n_missed;
    bit          tick;

    function automatic logic [31:0] target_of(input logic [15:0] p);
        longint uu = longint'($signed(p)) + 32768;
        return m_base + 32'((uu * longint'(m_dur)) >> 16);
    endfunction

    task automatic model_reset();
        started = 0; inflight = 0; q.delete(); m_fire = 0; m_missed = 0; m_busy = 0;
    endtask

    task automatic model_edge(input logic acc);
        logic popnow, late;
        logic signed [31:0] dd;
        m_fire = 0;
        m_missed = 0;
        if (sync_start) begin
            q.delete();
            inflight = 0;
            started = 1;
            m_base = sig_time;
            m_dur = dir ? afll_rtl : afll_ltr;
            free_e = cyc + 1;
        end else if (started) begin
            popnow = !inflight && cyc >= free_e && q.size() > 0;
            if (inflight && cyc >= inf_c) begin
                dd = sig_time - inf_t;
                if (dd >= 0) begin
                    late = (cyc == inf_c) && (dd > 0);
                    inflight = 0;
                    m_missed = late;
                    m_fire = 1;
                    m_ft = inf_t;
                    free_e = cyc + 2;
`ifdef GROOVE_SCHED_SKIP_LATE_EN
                    if (late) begin
                        m_fire = 0;
                        free_e = cyc + 1;
                    end
`endif
                end
            end
            if (popnow) begin
                inflight = 1;
                inf_t = q.pop_front();
                inf_c = cyc + 3;
            end
            if (acc) q.push_back(target_of(pos_in));
        end
        m_busy = q.size() != 0 || inflight || m_fire;
    endtask

    task automatic step(output logic acc);
        logic exp_ready;
        #1;
        exp_ready = started && q.size() < DEPTH && !sync_start;
        check("pos_ready", 32'(pos_ready), 32'(exp_ready));
        acc = pos_valid && exp_ready;
        @(posedge clk);
        cyc++;
        model_edge(acc);
        @(negedge clk);
        check("fire", 32'(fire), 32'(m_fire));
        check("missed", 32'(missed), 32'(m_missed));
        check("busy", 32'(busy), 32'(m_busy));
        if (m_fire) check("fire_time", fire_time, m_ft);
        if (fire) begin
            obs_ft.push_back(fire_time);
            obs_sig.push_back(sig_time);
        end
        if (missed) n_missed++;
        if (tick) sig_time++;
    endtask

    task automatic run(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic clear_obs();
        obs_ft.delete(); obs_sig.delete(); n_missed = 0;
    endtask

    task automatic do_sync(input logic [31:0] t, input logic dr, input logic [31:0] ltr, input logic [31:0] rtl);
        logic a;
        sig_time = t; dir = dr; afll_ltr = ltr; afll_rtl = rtl; sync_start = 1;
        step(a);
        sync_start = 0;
    endtask

    task automatic push_req(input logic [15:0] p);
        logic a;
        int n = 0;
        pos_valid = 1; pos_in = p;
        do begin step(a); n++; end while (!a && n < 3000);
        pos_valid = 0;
        check("push_accepted", 32'(a), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin run(1); n++; end while ((m_busy || busy) && n < 5000);
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic a;
        int acc_n, n;
        reset = 1; sync_start = 0; sig_time = 0; dir = 0; afll_ltr = 0; afll_rtl = 0;
        pos_valid = 0; pos_in = 0; tick = 0; cyc = 0; free_e = 0;
        model_reset();
        clear_obs();
        repeat (3) @(negedge clk);
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_missed", 32'(missed), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(pos_ready), 32'd0);
        check("rst_fire_time", fire_time, 32'd0);
        reset = 0;
        pos_valid = 1;
        run(2);
        pos_valid = 0;

        // Basic scheduling with sig_time frozen until the first target fires.
        clear_obs();
        do_sync(5000, 0, 1000, 0);
        push_req(16'h8000);
        push_req(16'h0000);
        push_req(16'h7fff);
        n = 0;
        while (obs_ft.size() == 0 && n < 50) begin run(1); n++; end
        tick = 1;
        wait_idle();
        check("basic_count", obs_ft.size(), 3);
        check("basic_t0", obs_ft.size() > 0 ? obs_ft[0] : 32'hx, 5000);
        check("basic_t1", obs_ft.size() > 1 ? obs_ft[1] : 32'hx, 5500);
        check("basic_t2", obs_ft.size() > 2 ? obs_ft[2] : 32'hx, 5999);
        check("basic_missed", n_missed, 0);

        // Direction select; later dir/afll changes must not matter.
        clear_obs();
        do_sync(0, 1, 1000, 2000);
        dir = 0; afll_rtl = 7;
        push_req(16'h0000);
        wait_idle();
        check("dir_count", obs_ft.size(), 1);
        check("dir_t", obs_ft.size() > 0 ? obs_ft[0] : 32'hx, 1000);

        // Wrap-around target.
        clear_obs();
        do_sync(32'hFFFFFF00, 0, 32'h400, 0);
        push_req(16'h0000);
        wait_idle();
        check("wrap_t", obs_ft.size() > 0 ? obs_ft[0] : 32'hx, 32'h100);
        check("wrap_sig", obs_sig.size() > 0 ? obs_sig[0] : 32'hx, 32'h100);

        // Late target.
        clear_obs();
        tick = 0;
        do_sync(5000, 0, 1000, 0);
        sig_time = 5100;
        push_req(16'h8000);
        wait_idle();
        check("late_missed", n_missed, 1);
`ifdef GROOVE_SCHED_SKIP_LATE_EN
        check("late_nofire", obs_ft.size(), 0);
`else
        check("late_fire", obs_ft.size() > 0 ? obs_ft[0] : 32'hx, 5000);
`endif

        // FIFO full with a far first target, then flush.
        tick = 1;
        do_sync(0, 0, 2000, 0);
        acc_n = 0;
        pos_valid = 1;
        for (int i = 0; i < 20; i++) begin
            pos_in = (acc_n == 0) ? 16'h7fff : 16'h8000;
            step(a);
            if (a) acc_n++;
        end
        pos_valid = 0;
        check("full_accepts", acc_n, 5);
        run(5);
        clear_obs();
        do_sync(20000, 0, 1000, 0);
        run(30);
        check("flush_nofire", obs_ft.size(), 0);
        check("flush_nomissed", n_missed, 0);
        push_req(16'h0000);
        wait_idle();
        check("flush_new", obs_ft.size() > 0 ? obs_ft[0] : 32'hx, 20500);

        // Reset while a target waits.
        do_sync(0, 0, 2000, 0);
        push_req(16'h7fff);
        run(10);
        reset = 1;
        #1;
        check("mid_rst_fire", 32'(fire), 32'd0);
        check("mid_rst_missed", 32'(missed), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(pos_ready), 32'd0);
        check("mid_rst_fire_time", fire_time, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        pos_valid = 1;
        run(2);
        pos_valid = 0;

        // Randomized traffic crossing the timestamp wrap.
        do_sync(32'hFFFFF000, 0, 100, 0);
        for (int i = 0; i < 4000; i++) begin
            sync_start = ($urandom_range(0, 299) == 0);
            dir = 1'($urandom);
            afll_ltr = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 400);
            afll_rtl = $urandom_range(0, 400);
            pos_valid = ($urandom_range(0, 2) == 0);
            pos_in = 16'($urandom);
            step(a);
        end
        sync_start = 0;
        pos_valid = 0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
